// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and default vectors for the PC sequencer and its PC mux.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_JUMP   = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_EXC    = 2'd3
  } cause_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int          DEF_CNT_W        = 16;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_mux.sv
// Next-PC selector: picks the redirect target or the sequential PC+4.
module PC_Mux (
  input  logic        sel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  output logic [31:0] pc_next_o
);

  assign pc_next_o = sel_i ? reg1_i : reg2_i;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: arbitrates redirects against fetch, stall and halt,
// and drives the PC mux selector, pipeline flushes and fetch qualifier.
//
// state | meaning
// BOOT  | single post-reset cycle, no fetch, inputs ignored
// RUN   | normal fetch with fixed-priority redirect arbitration
// HALT  | PC frozen; only an exception restarts fetch
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             exc_i,
  input  logic             halt_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [31:0]      redirect_target_o,
  output logic             pc_sel_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             fetch_valid_o,
  output logic [1:0]       cause_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_count_o
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_next;
  logic             pc_en;
  cause_e           cause;

  assign pc_plus4_o = pc_q + 32'd4;

  always_comb begin
    state_d           = state_q;
    pc_en             = 1'b0;
    pc_sel_o          = 1'b0;
    redirect_target_o = pc_plus4_o;
    flush_if_o        = 1'b0;
    flush_id_o        = 1'b0;
    fetch_valid_o     = 1'b0;
    misalign_o        = 1'b0;
    cause             = CAUSE_NONE;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;

      ST_RUN: begin
        fetch_valid_o = !stall_i;
        if (exc_i) begin
          cause             = CAUSE_EXC;
          redirect_target_o = EXC_VECTOR;
        end else if (branch_taken_i) begin
          cause             = CAUSE_BRANCH;
          redirect_target_o = branch_target_i;
        end else if (jump_i) begin
          cause             = CAUSE_JUMP;
          redirect_target_o = jump_target_i;
        end

        // A misaligned branch/jump becomes an exception redirect
        if ((cause == CAUSE_BRANCH || cause == CAUSE_JUMP) &&
            is_misaligned(redirect_target_o[1:0])) begin
          cause             = CAUSE_EXC;
          redirect_target_o = EXC_VECTOR;
          misalign_o        = 1'b1;
        end

        if (cause == CAUSE_NONE) begin
          if (halt_i)        state_d = ST_HALT;
          else if (!stall_i) pc_en   = 1'b1;
        end
      end

      ST_HALT: begin
        if (exc_i) begin
          cause             = CAUSE_EXC;
          redirect_target_o = EXC_VECTOR;
          state_d           = ST_RUN;
        end
      end

      default: state_d = ST_BOOT;
    endcase

    // Redirects override stall: the redirecting instruction is older
    if (cause != CAUSE_NONE) begin
      pc_sel_o   = 1'b1;
      pc_en      = 1'b1;
      flush_if_o = 1'b1;
      flush_id_o = (cause != CAUSE_JUMP);
    end
  end

  assign cause_o = cause;

  PC_Mux u_pc_mux (
    .sel_i     (pc_sel_o),
    .reg1_i    (redirect_target_o),
    .reg2_i    (pc_plus4_o),
    .pc_next_o (pc_next)
  );

  assign pc_d  = pc_en ? pc_next : pc_q;
  assign cnt_d = (pc_sel_o && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o             = pc_q;
  assign redirect_count_o = cnt_q;

endmodule
